// File: rtl/blast_engine.sv
// Resolves one bomb detonation against the tile map: clears the bomb tile, walks the four arms,
// destroys the first destroyable block per arm and reports flame coverage and chained bombs.
module blast_engine #(
    parameter int NUM_ROW    = 13,
    parameter int NUM_COL    = 19,
    parameter int DATA_WIDTH = 2,
    parameter int RANGE_W    = 3,
    localparam int ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_over,
    input  logic                  det_valid,
    output logic                  det_ready,
    input  logic [ADDR_WIDTH-1:0] det_addr,
    input  logic [RANGE_W-1:0]    det_range,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  flame_valid,
    output logic [ADDR_WIDTH-1:0] flame_addr,
    output logic                  chain_valid,
    output logic [ADDR_WIDTH-1:0] chain_addr,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_dbg
);

    // Handshake: a request is taken on the rising edge where det_valid && det_ready && !game_over;
    // det_ready is high exactly while the engine sits in IDLE.

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CENTER = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_EVAL   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [DATA_WIDTH-1:0] T_EMPTY = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] T_DESTR = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] T_BOMB  = DATA_WIDTH'(3);

    localparam int ROW_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int MAX_W = (ROW_W > COL_W) ? ROW_W : COL_W;
    // Signed step arithmetic must hold row/col plus a step of up to 2**RANGE_W, and go negative.
    localparam int CW    = ((MAX_W > RANGE_W) ? MAX_W : RANGE_W) + 2;

    localparam logic signed [CW-1:0]  ROW_LIM = CW'(NUM_ROW);
    localparam logic signed [CW-1:0]  COL_LIM = CW'(NUM_COL);
    localparam logic [ADDR_WIDTH-1:0] COL_A   = ADDR_WIDTH'(NUM_COL);
    localparam logic [RANGE_W:0]      K_ONE   = (RANGE_W + 1)'(1);

    logic [2:0]         state_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [RANGE_W-1:0] range_q;
    logic [1:0]         dir_q;
    logic [RANGE_W:0]   k_q;

    logic signed [CW-1:0]  row_s, col_s, k_s, t_row, t_col;
    logic                  tgt_ok;
    logic [ADDR_WIDTH-1:0] tgt_addr;
    logic                  arm_end;

    always_comb begin
        row_s = $signed(CW'(row_q));
        col_s = $signed(CW'(col_q));
        k_s   = $signed(CW'(k_q));
        t_row = row_s;
        t_col = col_s;
        case (dir_q)
            DIR_UP:   t_row = row_s - k_s;
            DIR_DOWN: t_row = row_s + k_s;
            DIR_LEFT: t_col = col_s - k_s;
            default:  t_col = col_s + k_s;
        endcase
        // Column bound is checked on the column alone so an arm never wraps onto a neighbouring row.
        tgt_ok = (k_q <= {1'b0, range_q})
              && !t_row[CW-1] && (t_row < ROW_LIM)
              && !t_col[CW-1] && (t_col < COL_LIM);
        tgt_addr = ADDR_WIDTH'($unsigned(t_row)) * COL_A + ADDR_WIDTH'($unsigned(t_col));
    end

    always_comb begin
        arm_end = 1'b0;
        if (state_q == S_ISSUE && !tgt_ok)
            arm_end = 1'b1;
        if (state_q == S_EVAL && rd_data != T_EMPTY)
            arm_end = 1'b1;
    end

    assign det_ready = (state_q == S_IDLE);
    assign rd_addr   = (state_q == S_ISSUE && tgt_ok) ? tgt_addr : '0;
    assign wr_data   = '0;
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            range_q     <= '0;
            dir_q       <= DIR_UP;
            k_q         <= '0;
            we          <= 1'b0;
            wr_addr     <= '0;
            flame_valid <= 1'b0;
            flame_addr  <= '0;
            chain_valid <= 1'b0;
            chain_addr  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            we          <= 1'b0;
            flame_valid <= 1'b0;
            chain_valid <= 1'b0;
            done        <= 1'b0;
            if (game_over) begin
                state_q <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (det_valid) begin
                            // The bomb-tile clear and its flame are launched here so they show during CENTER.
                            row_q       <= ROW_W'(det_addr / COL_A);
                            col_q       <= COL_W'(det_addr % COL_A);
                            range_q     <= det_range;
                            busy        <= 1'b1;
                            we          <= 1'b1;
                            wr_addr     <= det_addr;
                            flame_valid <= 1'b1;
                            flame_addr  <= det_addr;
                            state_q     <= S_CENTER;
                        end
                    end
                    S_CENTER: begin
                        dir_q   <= DIR_UP;
                        k_q     <= K_ONE;
                        state_q <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (tgt_ok)
                            state_q <= S_EVAL;
                    end
                    S_EVAL: begin
                        if (rd_data == T_EMPTY || rd_data == T_DESTR || rd_data == T_BOMB) begin
                            flame_valid <= 1'b1;
                            flame_addr  <= tgt_addr;
                        end
                        if (rd_data == T_DESTR) begin
                            we      <= 1'b1;
                            wr_addr <= tgt_addr;
                        end
                        if (rd_data == T_BOMB) begin
                            chain_valid <= 1'b1;
                            chain_addr  <= tgt_addr;
                        end
                        if (rd_data == T_EMPTY) begin
                            k_q     <= k_q + 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                    S_DONE: begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
                if (arm_end) begin
                    if (dir_q == DIR_RIGHT) begin
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        dir_q   <= dir_q + 1'b1;
                        k_q     <= K_ONE;
                        state_q <= S_ISSUE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_blast_engine.sv
// Directed bench for blast_engine on a 13x19 map with a synchronous-read map model.
module tb_blast_engine;
    localparam int NR = 13;
    localparam int NC = 19;
    localparam int DW = 2;
    localparam int RW = 3;
    localparam int AW = 8;
    localparam int NT = NR * NC;

    localparam logic [DW-1:0] T_PERM  = 2'd1;
    localparam logic [DW-1:0] T_DESTR = 2'd2;
    localparam logic [DW-1:0] T_BOMB  = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          game_over;
    logic          det_valid;
    logic          det_ready;
    logic [AW-1:0] det_addr;
    logic [RW-1:0] det_range;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          flame_valid;
    logic [AW-1:0] flame_addr;
    logic          chain_valid;
    logic [AW-1:0] chain_addr;
    logic          busy;
    logic          done;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    blast_engine #(.NUM_ROW(NR), .NUM_COL(NC), .DATA_WIDTH(DW), .RANGE_W(RW)) dut (
        .clk(clk), .rst(rst), .game_over(game_over),
        .det_valid(det_valid), .det_ready(det_ready), .det_addr(det_addr), .det_range(det_range),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .flame_valid(flame_valid), .flame_addr(flame_addr),
        .chain_valid(chain_valid), .chain_addr(chain_addr),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Map model: one-cycle synchronous read; contents are set only by the stimulus.
    logic [DW-1:0] map_mem [NT];
    always @(posedge clk)
        rd_data <= (int'(rd_addr) < NT) ? map_mem[rd_addr] : '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] flame_log[$];
    logic [AW-1:0] wr_log[$];
    logic [AW-1:0] chain_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sel: 0 = flame log, 1 = write log, 2 = chain log; compared against exp_q in order.
    task automatic check_list(input string tag, input int sel);
        logic [AW-1:0] got[$];
        bit ok;
        int bad;
        case (sel)
            0:       got = flame_log;
            1:       got = wr_log;
            default: got = chain_log;
        endcase
        ok  = (got.size() == exp_q.size());
        bad = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (bad < 0 && got[i] !== exp_q[i]) begin
                ok  = 1'b0;
                bad = i;
            end
        n_checks++;
        assert (ok) n_pass++;
        else begin
            n_fail++;
            if (bad >= 0)
                $error("FAIL %s: item %0d observed %0d expected %0d", tag, bad, got[bad], exp_q[bad]);
            else
                $error("FAIL %s: observed %0d items expected %0d items", tag, got.size(), exp_q.size());
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < NT; i++)
            map_mem[i] = '0;
    endtask

    // e counts cycles after the accept edge; e=1 is the CENTER cycle. abort_at>0 raises game_over in cycle abort_at.
    task automatic run_blast(input logic [AW-1:0] a, input logic [RW-1:0] r, input int abort_at,
                             output int done_e);
        flame_log.delete();
        wr_log.delete();
        chain_log.delete();
        done_e = -1;
        @(negedge clk);
        det_valid = 1'b1;
        det_addr  = a;
        det_range = r;
        chk("ready_before_accept", det_ready, 1);
        @(posedge clk);
        @(negedge clk);
        det_valid = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            if (e > 1) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (flame_valid) flame_log.push_back(flame_addr);
            if (we)          wr_log.push_back(wr_addr);
            if (chain_valid) chain_log.push_back(chain_addr);
            if (e == 1) begin
                chk("busy_after_accept", busy, 1);
                chk("not_ready_when_busy", det_ready, 0);
            end
            if (abort_at > 0) begin
                if (e == abort_at) game_over = 1'b1;
                if (e == abort_at + 1) begin
                    game_over = 1'b0;
                    chk("abort_ready", det_ready, 1);
                    chk("abort_busy", busy, 0);
                end
                if (e == abort_at + 6) break;
            end
            if (done) begin
                done_e = e;
                break;
            end
        end
        if (abort_at == 0) begin
            if (done_e < 0)
                chk("done_timeout", 0, 1);
            @(posedge clk);
            @(negedge clk);
            chk("ready_after_done", det_ready, 1);
        end
    endtask

    int d;
    int n18;

    initial begin
        rst       = 1'b1;
        game_over = 1'b0;
        det_valid = 1'b0;
        det_addr  = '0;
        det_range = '0;
        clear_map();
        #1;
        chk("rst_ready", det_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_we", we, 0);
        chk("rst_flame", flame_valid, 0);
        chk("rst_chain", chain_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Bomb at r1 c1, range 2: UP hits perm at 1, DOWN runs to 58, LEFT perm 19, RIGHT destroys 21.
        clear_map();
        map_mem[1]  = T_PERM;
        map_mem[19] = T_PERM;
        map_mem[21] = T_DESTR;
        run_blast(8'd20, 3'd2, 0, d);
        chk("t1_done_cycle", d, 13);
        exp_q = '{8'd20, 8'd39, 8'd58, 8'd21};
        check_list("t1_flames", 0);
        exp_q = '{8'd20, 8'd21};
        check_list("t1_writes", 1);
        chk("t1_chains", chain_log.size(), 0);

        // Bomb at r2 c2, range 3, bomb at 59 below it.
        clear_map();
        map_mem[59] = T_BOMB;
        run_blast(8'd40, 3'd3, 0, d);
        chk("t2_done_cycle", d, 21);
        exp_q = '{8'd40, 8'd21, 8'd2, 8'd59, 8'd39, 8'd38, 8'd41, 8'd42, 8'd43};
        check_list("t2_flames", 0);
        exp_q = '{8'd40};
        check_list("t2_writes", 1);
        exp_q = '{8'd59};
        check_list("t2_chains", 2);

        // Range 0: only the bomb tile; done in the 7th cycle counting the accept cycle.
        clear_map();
        run_blast(8'd100, 3'd0, 0, d);
        chk("t3_done_cycle", d, 6);
        exp_q = '{8'd100};
        check_list("t3_flames", 0);
        check_list("t3_writes", 1);

        // Corner tile 0, range 7, empty map: UP and LEFT are off-grid immediately.
        clear_map();
        run_blast(8'd0, 3'd7, 0, d);
        chk("t4_done_cycle", d, 34);
        exp_q = '{8'd0, 8'd19, 8'd38, 8'd57, 8'd76, 8'd95, 8'd114, 8'd133,
                  8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        check_list("t4_flames", 0);
        exp_q = '{8'd0};
        check_list("t4_writes", 1);
        n18 = 0;
        foreach (flame_log[i])
            if (flame_log[i] == 8'd18) n18++;
        chk("t4_no_wrap_18", n18, 0);

        // game_over during the second EVAL (cycle 5): the DOWN flame at 39 must never appear.
        clear_map();
        map_mem[1]  = T_PERM;
        map_mem[19] = T_PERM;
        map_mem[21] = T_DESTR;
        run_blast(8'd20, 3'd2, 5, d);
        chk("t5_no_done", d, -1);
        exp_q = '{8'd20};
        check_list("t5_flames", 0);
        check_list("t5_writes", 1);

        // Asynchronous reset between clock edges while in CENTER.
        clear_map();
        @(negedge clk);
        det_valid = 1'b1;
        det_addr  = 8'd40;
        det_range = 3'd3;
        @(posedge clk);
        @(negedge clk);
        det_valid = 1'b0;
        chk("t6_we_before_rst", we, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we", we, 0);
        chk("t6_rst_flame", flame_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", det_ready, 1);
        chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_flame_addr", flame_addr, 0);
        #1 rst = 1'b0;
        run_blast(8'd100, 3'd0, 0, d);
        chk("t6_after_rst_done", d, 6);
        exp_q = '{8'd100};
        check_list("t6_after_rst_flames", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
